// File: rtl/tinyrv1_mem_responder.sv
// Memory responder: word array behind a val/rdy request port, answering every
// request in order after LAT cycles through a DEPTH-entry response queue.
module tinyrv1_mem_responder #(
  parameter int AW    = 10,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic        memreq_type,
  input  logic [31:0] memreq_addr,
  input  logic [31:0] memreq_wdata,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic        memresp_type,
  output logic [31:0] memresp_data,
  input  logic        bd_wen,
  input  logic [31:0] bd_addr,
  input  logic [31:0] bd_wdata
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
  } resp_t;

  logic [31:0]   mem [2**AW];
  logic [CW-1:0] outstanding;
  logic          req_fire, resp_fire;
  logic [AW-1:0] req_idx, bd_idx;
  resp_t         acc_resp, enq_resp, head;
  logic          enq_val;

  resp_t         fifo [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;

  // Low two bits and everything above AW+1 are dropped, so addresses alias.
  assign req_idx  = memreq_addr[AW+1:2];
  assign bd_idx   = bd_addr[AW+1:2];

  // Outstanding covers pipeline plus queue, which is what keeps the queue from overflowing.
  assign memreq_rdy = ~rst & (outstanding < CW'(DEPTH));
  assign req_fire   = memreq_val & memreq_rdy;
  assign resp_fire  = memresp_val & memresp_rdy;

  // Read data is sampled before this edge's writes land.
  assign acc_resp.typ  = memreq_type;
  assign acc_resp.data = memreq_type ? 32'h0 : mem[req_idx];

  // Backdoor first so a same-word request write overrides it.
  always_ff @(posedge clk) begin
    if (bd_wen) mem[bd_idx] <= bd_wdata;
    if (req_fire && memreq_type) mem[req_idx] <= memreq_wdata;
  end

  // Track requests accepted but not yet handed back.
  always_ff @(posedge clk) begin
    if (rst) outstanding <= '0;
    else     outstanding <= outstanding + CW'(req_fire) - CW'(resp_fire);
  end

  // Latency pipeline: LAT-1 register stages; the accept edge itself counts as one.
  generate
    if (LAT == 1) begin : g_nopipe
      assign enq_val  = req_fire;
      assign enq_resp = acc_resp;
    end else begin : g_pipe
      logic [LAT-1:1] vld_pipe;
      resp_t          resp_pipe [LAT-1:1];

      // Valid bits shift every cycle and are cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else begin
          vld_pipe[1] <= req_fire;
          for (int i = 2; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      // Payload rides alongside the valid bits; no reset needed.
      always_ff @(posedge clk) begin
        resp_pipe[1] <= acc_resp;
        for (int i = 2; i < LAT; i++) resp_pipe[i] <= resp_pipe[i-1];
      end

      assign enq_val  = vld_pipe[LAT-1];
      assign enq_resp = resp_pipe[LAT-1];
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Queue pointers and fill count; enqueue and dequeue may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (enq_val)   wr_ptr <= ptr_inc(wr_ptr);
      if (resp_fire) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(enq_val) - CW'(resp_fire);
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (enq_val) fifo[wr_ptr] <= enq_resp;
  end

  assign head         = fifo[rd_ptr];
  assign memresp_val  = ~rst & (fifo_cnt != '0);
  assign memresp_type = memresp_val ? head.typ  : 1'b0;
  assign memresp_data = memresp_val ? head.data : 32'h0;
endmodule

// File: tb/tb_tinyrv1_mem_responder.sv
// Directed bench: instance a runs LAT=1, instance b runs LAT=3; both DEPTH=4.
module tb_tinyrv1_mem_responder;
  logic clk = 0, rst = 1;
  logic bd_wen = 0;
  logic [31:0] bd_addr = 0, bd_wdata = 0;

  logic a_req_val = 0, a_req_rdy, a_req_type = 0, a_resp_val, a_resp_rdy = 1, a_resp_type;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_resp_data;
  logic b_req_val = 0, b_req_rdy, b_req_type = 0, b_resp_val, b_resp_rdy = 1, b_resp_type;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_resp_data;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  tinyrv1_mem_responder #(.AW(10), .LAT(1), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst),
    .memreq_val(a_req_val), .memreq_rdy(a_req_rdy), .memreq_type(a_req_type),
    .memreq_addr(a_req_addr), .memreq_wdata(a_req_wdata),
    .memresp_val(a_resp_val), .memresp_rdy(a_resp_rdy), .memresp_type(a_resp_type),
    .memresp_data(a_resp_data),
    .bd_wen(bd_wen), .bd_addr(bd_addr), .bd_wdata(bd_wdata));

  tinyrv1_mem_responder #(.AW(10), .LAT(3), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst),
    .memreq_val(b_req_val), .memreq_rdy(b_req_rdy), .memreq_type(b_req_type),
    .memreq_addr(b_req_addr), .memreq_wdata(b_req_wdata),
    .memresp_val(b_resp_val), .memresp_rdy(b_resp_rdy), .memresp_type(b_resp_type),
    .memresp_data(b_resp_data),
    .bd_wen(bd_wen), .bd_addr(bd_addr), .bd_wdata(bd_wdata));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic bd_write(input logic [31:0] addr, input logic [31:0] data);
    bd_wen = 1; bd_addr = addr; bd_wdata = data;
    step();
    bd_wen = 0;
  endtask

  // Issue one request on a; its LAT=1 response is visible on return.
  task automatic a_req(input logic typ, input logic [31:0] addr, input logic [31:0] wdata);
    a_req_val = 1; a_req_type = typ; a_req_addr = addr; a_req_wdata = wdata;
    step();
    a_req_val = 0;
  endtask

  // Step until b presents a response, at most 10 cycles.
  task automatic b_wait(output bit got);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (b_resp_val) got = 1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    total++; if (a_req_rdy !== 1'b0 || b_req_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy a=%b b=%b want 0", a_req_rdy, b_req_rdy); end
    total++; if (a_resp_val !== 1'b0 || b_resp_val !== 1'b0) begin bad++; $display("FAIL reset_val a=%b b=%b want 0", a_resp_val, b_resp_val); end
    rst = 0;
    #1;
    total++; if (a_req_rdy !== 1'b1 || b_req_rdy !== 1'b1) begin bad++; $display("FAIL post_reset_rdy a=%b b=%b want 1", a_req_rdy, b_req_rdy); end
    total++; if (a_resp_data !== 32'h0) begin bad++; $display("FAIL idle_data got=%h want 0", a_resp_data); end
  endtask

  task automatic test_read();
    bd_write(32'h100, 32'hDEADBEEF);
    a_req(1'b0, 32'h100, 32'h0);
    total++; if (a_resp_val !== 1'b1 || a_resp_type !== 1'b0 || a_resp_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_lat1 val=%b type=%b data=%h want 1/0/deadbeef", a_resp_val, a_resp_type, a_resp_data); end
    step();
    total++; if (a_resp_val !== 1'b0 || a_resp_data !== 32'h0 || a_req_rdy !== 1'b1) begin
      bad++; $display("FAIL read_drain val=%b data=%h rdy=%b want 0/0/1", a_resp_val, a_resp_data, a_req_rdy); end
  endtask

  task automatic test_write_read();
    a_req_val = 1; a_req_type = 1; a_req_addr = 32'h204; a_req_wdata = 32'h12345678;
    step();
    a_req_type = 0;
    total++; if (a_resp_val !== 1'b1 || a_resp_type !== 1'b1 || a_resp_data !== 32'h0) begin
      bad++; $display("FAIL wr_resp val=%b type=%b data=%h want 1/1/0", a_resp_val, a_resp_type, a_resp_data); end
    step();
    a_req_addr = 32'h206;
    total++; if (a_resp_val !== 1'b1 || a_resp_type !== 1'b0 || a_resp_data !== 32'h12345678) begin
      bad++; $display("FAIL rd_after_wr val=%b type=%b data=%h want 1/0/12345678", a_resp_val, a_resp_type, a_resp_data); end
    step();
    a_req_val = 0;
    total++; if (a_resp_val !== 1'b1 || a_resp_data !== 32'h12345678) begin
      bad++; $display("FAIL rd_lowbits val=%b data=%h want 1/12345678", a_resp_val, a_resp_data); end
    step();
    total++; if (a_resp_val !== 1'b0) begin bad++; $display("FAIL wr_rd_drain val=%b want 0", a_resp_val); end
  endtask

  task automatic test_alias_collide();
    a_req(1'b1, 32'h1008, 32'hA5A50008);
    a_req(1'b0, 32'h8, 32'h0);
    total++; if (a_resp_data !== 32'hA5A50008) begin bad++; $display("FAIL alias got=%h want a5a50008", a_resp_data); end
    // Backdoor and request write on the same word at the same edge.
    bd_wen = 1; bd_addr = 32'h300; bd_wdata = 32'h11111111;
    a_req(1'b1, 32'h300, 32'h22222222);
    bd_wen = 0;
    a_req(1'b0, 32'h300, 32'h0);
    total++; if (a_resp_data !== 32'h22222222) begin bad++; $display("FAIL bd_vs_wr got=%h want 22222222", a_resp_data); end
    // Backdoor write against a request read of the same word.
    bd_write(32'h304, 32'h0BADF00D);
    bd_wen = 1; bd_addr = 32'h304; bd_wdata = 32'h33333333;
    a_req(1'b0, 32'h304, 32'h0);
    bd_wen = 0;
    total++; if (a_resp_data !== 32'h0BADF00D) begin bad++; $display("FAIL bd_vs_rd got=%h want 0badf00d", a_resp_data); end
    a_req(1'b0, 32'h304, 32'h0);
    total++; if (a_resp_data !== 32'h33333333) begin bad++; $display("FAIL bd_after_rd got=%h want 33333333", a_resp_data); end
    step();
  endtask

  task automatic test_full();
    for (int k = 0; k < 5; k++) bd_write(32'(4 * k), 32'h1000 + 32'(k));
    b_resp_rdy = 0;
    b_req_val = 1; b_req_type = 0;
    for (int k = 0; k < 4; k++) begin
      b_req_addr = 32'(4 * k);
      total++; if (b_req_rdy !== 1'b1) begin bad++; $display("FAIL full_accept%0d rdy=%b want 1", k, b_req_rdy); end
      step();
    end
    b_req_addr = 32'h10;
    step(); step(); step();
    total++; if (b_req_rdy !== 1'b0) begin bad++; $display("FAIL full_blocked rdy=%b want 0", b_req_rdy); end
    total++; if (b_resp_val !== 1'b1 || b_resp_data !== 32'h1000) begin
      bad++; $display("FAIL full_head val=%b data=%h want 1/1000", b_resp_val, b_resp_data); end
    b_resp_rdy = 1;
    step();
    total++; if (b_req_rdy !== 1'b1 || b_resp_data !== 32'h1001) begin
      bad++; $display("FAIL first_drain rdy=%b data=%h want 1/1001", b_req_rdy, b_resp_data); end
    step();
    b_req_val = 0;
    for (int k = 2; k < 5; k++) begin
      total++; if (b_resp_val !== 1'b1 || b_resp_data !== 32'h1000 + 32'(k)) begin
        bad++; $display("FAIL full_order%0d val=%b data=%h want 1/%h", k, b_resp_val, b_resp_data, 32'h1000 + 32'(k)); end
      step();
    end
    total++; if (b_resp_val !== 1'b0) begin bad++; $display("FAIL full_empty val=%b want 0", b_resp_val); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int nacc = 0, nresp = 0, gaps = 0, errs = 0;
    bit acc, rsp;
    for (int k = 0; k < 40; k++) bd_write(32'(4 * k), 32'hC0DE0000 | 32'(k));
    b_req_val = 1; b_req_type = 0; b_req_addr = 0; b_resp_rdy = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 6) b_resp_rdy = 1;
      if (i == 30) b_req_val = 0;
      acc = b_req_val & b_req_rdy;
      rsp = b_resp_val & b_resp_rdy;
      if (i >= 8 && i < 30 && !(acc && rsp)) gaps++;
      if (rsp) begin
        nresp++;
        if (exp_q.size() == 0) errs++;
        else begin
          e = exp_q.pop_front();
          if (b_resp_data !== e) errs++;
        end
      end
      if (acc) begin
        exp_q.push_back(32'hC0DE0000 | 32'(nacc));
        nacc++;
      end
      step();
      b_req_addr = 32'(4 * nacc);
    end
    total++; if (errs != 0) begin bad++; $display("FAIL b2b_data errors=%0d want 0", errs); end
    total++; if (gaps != 0) begin bad++; $display("FAIL b2b_sustain gaps=%0d want 0", gaps); end
    total++; if (nresp != nacc || nacc < 25 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count acc=%0d resp=%0d left=%0d want equal, >=25, 0", nacc, nresp, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit got;
    int stale = 0;
    b_req_val = 1; b_req_type = 1; b_req_addr = 32'h40; b_req_wdata = 32'h5EED5EED;
    step();
    b_req_val = 0; b_req_type = 0;
    b_wait(got);
    step();
    b_resp_rdy = 0;
    b_req_val = 1;
    for (int k = 0; k < 3; k++) begin b_req_addr = 32'(4 * k); step(); end
    b_req_val = 0;
    rst = 1;
    step();
    total++; if (b_resp_val !== 1'b0 || b_req_rdy !== 1'b0) begin
      bad++; $display("FAIL mid_reset val=%b rdy=%b want 0/0", b_resp_val, b_req_rdy); end
    step();
    rst = 0;
    #1;
    total++; if (b_req_rdy !== 1'b1) begin bad++; $display("FAIL mid_reset_rdy rdy=%b want 1", b_req_rdy); end
    for (int i = 0; i < 6; i++) begin if (b_resp_val !== 1'b0) stale++; step(); end
    total++; if (stale != 0) begin bad++; $display("FAIL stale_resp cycles=%0d want 0", stale); end
    b_resp_rdy = 1;
    b_req_val = 1; b_req_addr = 32'h40;
    step();
    b_req_val = 0;
    b_wait(got);
    total++; if (!got || b_resp_data !== 32'h5EED5EED) begin
      bad++; $display("FAIL persist got=%0d data=%h want 1/5eed5eed", got, b_resp_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_alias_collide();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
